// File: rtl/dsp_inst_sequencer_if.sv
// dsp_inst_sequencer_if: host write path and controller-side signals of the instruction sequencer.
interface dsp_inst_sequencer_if #(parameter int DEPTH = 16);
    logic [31:0]             in_inst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    run_en;
    logic                    step;
    logic [31:0]             inst_out;
    logic                    busy;
    logic [$clog2(DEPTH):0]  level;
    logic [15:0]             done_cnt;
    modport master (output in_inst, in_valid, run_en, step,
                    input  in_ready, inst_out, busy, level, done_cnt);
    modport slave  (input  in_inst, in_valid, run_en, step,
                    output in_ready, inst_out, busy, level, done_cnt);
endinterface

// File: rtl/dsp_inst_sequencer.sv
// dsp_inst_sequencer: FIFO-buffered issue of instruction words, each held for the execute window then followed by a zero gap.
module dsp_inst_sequencer #(
    parameter int DEPTH       = 16,
    parameter int EXEC_CYCLES = 7,
    parameter int GAP_CYCLES  = 1
) (
    input logic                 clk,
    input logic                 rst,
    dsp_inst_sequencer_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int PMAX = EXEC_CYCLES > GAP_CYCLES ? EXEC_CYCLES : GAP_CYCLES;
    localparam int PW   = $clog2(PMAX) + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t          state, state_n;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   lvl;
    logic [PW-1:0]   phase, phase_n;
    logic [31:0]     head, inst_q, inst_n;
    logic [15:0]     done_q;
    logic            step_pending, push, pop, start, fin;
    assign head         = mem[rd_ptr];
    assign bus.in_ready = lvl != LW'(DEPTH);
    assign push         = bus.in_valid & bus.in_ready;
    assign bus.level    = lvl;
    assign bus.inst_out = inst_q;
    assign bus.done_cnt = done_q;
    assign bus.busy     = state != IDLE || lvl != '0;
    always_comb begin
        state_n = state;
        phase_n = phase;
        inst_n  = inst_q;
        pop     = 1'b0;
        start   = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                inst_n = '0;
                // words without the execute bit are dropped without occupying the controller
                if (lvl != '0 && !head[31]) pop = 1'b1;
                else if (lvl != '0 && (bus.run_en || step_pending)) begin
                    pop     = 1'b1;
                    start   = 1'b1;
                    inst_n  = head;
                    phase_n = '0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (phase == PW'(EXEC_CYCLES - 1)) begin
                    inst_n  = '0;
                    fin     = 1'b1;
                    phase_n = '0;
                    state_n = GAP;
                end else phase_n = phase + 1'b1;
            end
            GAP: begin
                if (phase == PW'(GAP_CYCLES - 1)) begin
                    phase_n = '0;
                    state_n = IDLE;
                end else phase_n = phase + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= bus.in_inst;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            inst_q       <= '0;
            done_q       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lvl          <= '0;
            step_pending <= 1'b0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            inst_q <= inst_n;
            if (fin) done_q <= done_q + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            lvl <= lvl + LW'(push) - LW'(pop);
            if (start) step_pending <= 1'b0;
            else if (bus.step && !bus.run_en) step_pending <= 1'b1;
        end
    end
endmodule

// File: doc/dsp_inst_sequencer.md
Name: dsp_inst_sequencer

Overview:
- Buffers 32-bit DSP/BRAM instruction words from a host and issues them one at a time to the BRAM/DSP instruction controller.
- Holds each word stable with execute (bit 31) set for the controller's full execute window.
- Then drives an all-zero gap so the controller re-arms before the next word.
- Sits between the host/debug write path and the controller's inst input; supports free-run and single-step operation.

Parameters:
- DEPTH, 16: instruction FIFO entries, power of two, at least 2.
- EXEC_CYCLES, 7: cycles a word is held on inst_out; covers controller counts 0..6, including the bram1 write at count 4.
- GAP_CYCLES, 1: cycles inst_out is driven to 0 after each word; at least 1.

Ports:
- clk, input, 1: clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- in_inst, input, 32: instruction word from host.
- in_valid, input, 1: in_inst is valid.
- in_ready, output, 1: FIFO can accept a word; equals (level != DEPTH).
- run_en, input, 1: level signal; 1 = free-run, issue whenever the FIFO is non-empty.
- step, input, 1: one-cycle pulse; when run_en=0, arms the issue of exactly one instruction.
- inst_out, output, 32: registered word to controller inst input.
- busy, output, 1: state != IDLE or level != 0.
- level, output, clog2(DEPTH)+1: FIFO occupancy.
- done_cnt, output, 16: number of instructions issued to completion.

Behaviour:
- Reset (rst=1 at posedge), values next cycle:
  - state=IDLE; FIFO emptied (level=0, pointers 0); inst_out=0; done_cnt=0; step_pending=0; phase counter=0.
  - in_ready=1 after reset.
  - Reset mid-ISSUE aborts the word: the popped word is discarded and not counted, and the controller sees execute=0 the following cycle.
- Push: when in_valid & in_ready at posedge, in_inst is written at the write pointer and level increments. Pointers wrap modulo DEPTH.
- in_ready is purely combinational from level. A push is refused when full even if a pop occurs in the same cycle.
- Pop: happens only on the IDLE decisions below. A simultaneous push and pop leaves level unchanged.
- step_pending: set at posedge when step=1 & run_en=0; cleared when a word enters ISSUE. A step while run_en=1 is ignored. Repeated steps before an issue do not accumulate.
- States:
  - IDLE:
    - inst_out=0.
    - If level != 0 and head[31]=0: pop and discard (NOP), stay in IDLE, done_cnt unchanged, step_pending unchanged.
    - Else if level != 0 and (run_en | step_pending): pop, inst_out <= head, phase <= 0, go to ISSUE.
  - ISSUE:
    - inst_out holds the word for exactly EXEC_CYCLES cycles; phase counts 0..EXEC_CYCLES-1.
    - On the last cycle: inst_out <= 0, done_cnt <= done_cnt+1 (wraps 0xFFFF->0), phase <= 0, go to GAP.
  - GAP:
    - inst_out=0 for GAP_CYCLES cycles, then go to IDLE.
    - run_en dropping during ISSUE or GAP does not truncate the current word.
- Latency:
  - Word pushed at posedge P into an empty FIFO with run_en=1 appears on inst_out after posedge P+1.
  - Back-to-back words are issued every EXEC_CYCLES+GAP_CYCLES+1 cycles (9 at defaults).
- Invariant: inst_out[31]=1 only in ISSUE. inst_out never changes within an ISSUE window.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> inst_out=0, level=0, in_ready=1, busy=0, done_cnt=0.
- Single word, run_en=1: push 0x8000_0421 at posedge P -> inst_out=0x8000_0421 for cycles P+1..P+7, 0 at P+8, done_cnt=1, busy=0 from P+9.
- Burst of 3 words (0x8000_0001, 0x8000_0002, 0x8000_0003) pushed back-to-back -> each held 7 cycles, first issue at P+1, starts spaced 9 cycles apart, at least 1 zero cycle between them, done_cnt=3, in_ready stays 1.
- Fill/full: run_en=0, push 17 words with DEPTH=16 -> in_ready=0 and level=16 after the 16th; 17th not accepted. Then run_en=1 -> in_ready=1 one cycle after the first pop; words issue in push order.
- Step mode: run_en=0, 2 words queued, one step pulse -> exactly one word issued, done_cnt=1, level=1. A second step -> the second word issues. A step while run_en=1 sets no pending.
- NOP skip and reset abort:
  - Queue 0x0000_0005 then 0x8000_0006 -> the NOP is dropped in 1 IDLE cycle and 0x8000_0006 issues; done_cnt=1.
  - rst at ISSUE phase 3 -> inst_out=0 next cycle, level=0, done_cnt=0.
